fetch_buffer_stage: RTL and testbench

- Instruction-fetch stage directly downstream of the next-PC register. It receives the current PC, issues synchronous instruction-memory reads, and buffers the returned instructions in a small FIFO.
- Presents {pc, pc+4, instr} to decode with a valid/ready handshake.
- Back-pressures the next-PC register through pc_hold, and discards all fetched/in-flight work on a branch/jump flush.

---
 rtl/fetch_buffer_stage.sv | 146 ++++++++++++++
 tb/tb_fetch_buffer_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buffer_stage
// Purpose  : Instruction-fetch stage sitting after the next-PC register.
//            Issues one synchronous instruction-memory read per accepted PC,
//            captures the returned word one cycle later, and queues
//            {pc, instr, misalign} in a small FIFO. Decode drains the FIFO
//            with a valid/ready handshake. A flush (redirect) empties the
//            FIFO and cancels the outstanding read.
// Ports    : clk          - clock, all state changes on rising edge
//            rst          - synchronous reset, active low
//            pc_in        - current PC from next-PC register
//            pc_hold      - next-PC must not advance (request not accepted)
//            flush        - redirect; drop buffered and in-flight fetches
//            imem_req     - instruction-memory read strobe
//            imem_addr    - instruction-memory read address
//            imem_rdata   - read data, valid one cycle after imem_req
//            id_valid     - FIFO head valid toward decode
//            id_ready     - decode accepts the head
//            id_pc        - head PC
//            id_pc_plus4  - head PC + 4 (wraps mod 2^32)
//            id_instr     - head instruction (0 for misaligned PCs)
//            id_misalign  - head PC not word aligned
// Revision : 1.0 - initial release
// ============================================================================
module fetch_buffer_stage #(
    parameter int BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    output logic        pc_hold,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [31:0] id_instr,
    output logic        id_misalign
);

    localparam int                 c_PTR_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int                 c_CNT_W     = $clog2(BUF_DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH     = c_CNT_W'(BUF_DEPTH);
    localparam logic [c_CNT_W:0]   c_DEPTH_EXT = (c_CNT_W + 1)'(BUF_DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);

    // FIFO storage (no reset: contents are only observed through a valid head)
    logic [31:0]        r_pc_q    [BUF_DEPTH];
    logic [31:0]        r_instr_q [BUF_DEPTH];
    logic               r_mis_q   [BUF_DEPTH];

    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;

    // Outstanding memory read, answered on the next cycle
    logic               r_inflight;
    logic [31:0]        r_inflight_pc;
    logic               r_inflight_mis;

    logic               w_head_valid;
    logic               w_pop;
    logic               w_push;
    logic               w_issue;
    logic [c_CNT_W:0]   w_occ;

    assign w_head_valid = rst & (r_count != '0);
    assign w_pop        = w_head_valid & id_ready;

    // The read answer is captured only while no redirect/reset is killing it;
    // a flush in the answer cycle is covered here, a flush one cycle earlier
    // already cleared r_inflight.
    assign w_push       = rst & ~flush & r_inflight;

    // Occupancy after this cycle, counting the outstanding read as a reserved
    // slot. A new read is issued only if it is guaranteed a slot next cycle,
    // which is what makes a push into a full FIFO impossible.
    assign w_occ        = {1'b0, r_count}
                        + {{c_CNT_W{1'b0}}, r_inflight}
                        - {{c_CNT_W{1'b0}}, w_pop};
    assign w_issue      = rst & ~flush & (w_occ < c_DEPTH_EXT);

    assign imem_req     = w_issue;
    assign imem_addr    = pc_in;
    assign pc_hold      = ~w_issue;

    // Control state: reset and flush share one clearing path
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_inflight <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_inflight <= w_issue;
        end
    end

    // Tag of the outstanding read; only meaningful while r_inflight is set
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_inflight_pc  <= pc_in;
            r_inflight_mis <= (pc_in[1:0] != 2'b00);
        end
    end

    // Misaligned fetches still perform the read but enqueue a nop (all zero)
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_q[r_wr_ptr]    <= r_inflight_pc;
            r_instr_q[r_wr_ptr] <= r_inflight_mis ? 32'h0000_0000 : imem_rdata;
            r_mis_q[r_wr_ptr]   <= r_inflight_mis;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (w_push) begin
            assert (r_count != c_DEPTH);
        end
    end
`endif

    assign id_valid    = w_head_valid;
    assign id_pc       = w_head_valid ? r_pc_q[r_rd_ptr]            : 32'h0000_0000;
    assign id_pc_plus4 = w_head_valid ? r_pc_q[r_rd_ptr] + 32'd4    : 32'h0000_0000;
    assign id_instr    = w_head_valid ? r_instr_q[r_rd_ptr]         : 32'h0000_0000;
    assign id_misalign = w_head_valid ? r_mis_q[r_rd_ptr]           : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_buffer_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_buffer_stage
// Purpose  : Self-checking bench for fetch_buffer_stage. A driver plays the
//            next-PC register and decode; a synchronous memory model answers
//            reads. A monitor keeps a transaction queue of expected entries
//            (issued read -> in-flight slot -> FIFO queue) and compares every
//            cycle; the driver adds directed checks on hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_buffer_stage;

    localparam int BUF_DEPTH = 2;

    logic        clk;
    logic        rst;
    logic [31:0] pc_in;
    logic        pc_hold;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_instr;
    logic        id_misalign;

    fetch_buffer_stage #(.BUF_DEPTH(BUF_DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_in       (pc_in),
        .pc_hold     (pc_hold),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_pc       (id_pc),
        .id_pc_plus4 (id_pc_plus4),
        .id_instr    (id_instr),
        .id_misalign (id_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Memory contents: a simple reversible pattern of the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[15:0]} ^ 32'h5A5A_C3C3;
    endfunction

    // Synchronous instruction memory: data valid the cycle after the request
    initial imem_rdata = 32'h0;
    always @(posedge clk) begin
        imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    end

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
    } ent_t;

    function automatic ent_t mk(input logic [31:0] pc);
        ent_t e;
        e.pc    = pc;
        e.mis   = (pc[1:0] != 2'b00);
        e.instr = e.mis ? 32'h0 : mem_word(pc);
        return e;
    endfunction

    ent_t q[$];
    ent_t infl_e;
    bit   infl = 1'b0;
    bit   m_ev, m_pop, m_er;
    int   m_occ;
    logic last_hold = 1'b1;

    always @(negedge clk) begin
        last_hold = pc_hold;
        m_ev = (rst === 1'b1) && (q.size() != 0);
        chk("id_valid", {31'b0, id_valid}, {31'b0, m_ev});
        if (m_ev) begin
            chk("id_pc",       id_pc,       q[0].pc);
            chk("id_pc_plus4", id_pc_plus4, q[0].pc + 32'd4);
            chk("id_instr",    id_instr,    q[0].instr);
            chk("id_misalign", {31'b0, id_misalign}, {31'b0, q[0].mis});
        end else begin
            chk("id_pc_idle",    id_pc,    32'h0);
            chk("id_instr_idle", id_instr, 32'h0);
        end
        m_pop = m_ev && (id_ready === 1'b1);
        m_occ = int'(q.size()) + int'(infl) - int'(m_pop);
        m_er  = (rst === 1'b1) && (flush === 1'b0) && (m_occ < BUF_DEPTH);
        chk("imem_req", {31'b0, imem_req}, {31'b0, m_er});
        chk("pc_hold",  {31'b0, pc_hold},  {31'b0, !m_er});
        if (m_er) chk("imem_addr", imem_addr, pc_in);
        if (rst !== 1'b1 || flush === 1'b1) begin
            q.delete();
            infl = 1'b0;
        end else begin
            if (m_pop) void'(q.pop_front());
            if (infl) q.push_back(infl_e);
            infl = m_er;
            if (m_er) infl_e = mk(pc_in);
        end
    end

    // ------------------------------------------------------------------
    // Driver: next-PC register + decode
    // ------------------------------------------------------------------
    task automatic next(input logic nrst, input logic fl, input logic rdy,
                        input logic ld, input logic [31:0] npc);
        logic adv;
        @(posedge clk);
        adv = !last_hold;
        #1;
        if (ld)       pc_in = npc;
        else if (adv) pc_in = pc_in + 32'd4;
        rst      = nrst;
        flush    = fl;
        id_ready = rdy;
    endtask

    task automatic go(input logic rdy);
        next(1'b1, 1'b0, rdy, 1'b0, 32'h0);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; id_ready = 1'b1; pc_in = 32'h3000;

        // Reset: outputs gated for two cycles
        @(negedge clk);
        chk("rst0_req",   {31'b0, imem_req}, 32'd0);
        chk("rst0_hold",  {31'b0, pc_hold},  32'd1);
        chk("rst0_valid", {31'b0, id_valid}, 32'd0);
        next(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("rst1_req",   {31'b0, imem_req}, 32'd0);
        chk("rst1_hold",  {31'b0, pc_hold},  32'd1);

        // First request after reset release
        go(1'b1);
        @(negedge clk);
        chk("start_req",  {31'b0, imem_req}, 32'd1);
        chk("start_addr", imem_addr, 32'h3000);
        go(1'b1);
        @(negedge clk);
        chk("start_lat_valid", {31'b0, id_valid}, 32'd0);

        // Streaming: eight back-to-back outputs
        for (int i = 0; i < 8; i++) begin
            go(1'b1);
            @(negedge clk);
            chk("stream_valid", {31'b0, id_valid}, 32'd1);
            chk("stream_pc",    id_pc, 32'h3000 + 32'(4 * i));
            chk("stream_hold",  {31'b0, pc_hold}, 32'd0);
            if (i == 0) begin
                chk("stream_plus4", id_pc_plus4, 32'h3004);
                chk("stream_instr", id_instr, 32'h3000_3000 ^ 32'h5A5A_C3C3);
            end
        end

        // Backpressure for five cycles
        for (int i = 0; i < 5; i++) begin
            go(1'b0);
            @(negedge clk);
        end
        chk("stall_hold",  {31'b0, pc_hold},  32'd1);
        chk("stall_valid", {31'b0, id_valid}, 32'd1);
        chk("stall_pc",    id_pc, 32'h3020);
        chk("stall_pcin",  pc_in, 32'h3028);
        go(1'b1);
        @(negedge clk);
        chk("resume_pc0",  id_pc, 32'h3020);
        chk("resume_hold", {31'b0, pc_hold}, 32'd0);
        go(1'b1);
        @(negedge clk);
        chk("resume_pc1",  id_pc, 32'h3024);
        go(1'b1);
        @(negedge clk);
        chk("resume_pc2",  id_pc, 32'h3028);

        // Flush while streaming (head consumed, read in flight)
        next(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("flush_req",   {31'b0, imem_req}, 32'd0);
        chk("flush_hold",  {31'b0, pc_hold},  32'd1);
        chk("flush_valid", {31'b0, id_valid}, 32'd1);
        next(1'b1, 1'b0, 1'b1, 1'b1, 32'h3040);
        @(negedge clk);
        chk("postflush_valid", {31'b0, id_valid}, 32'd0);
        chk("postflush_addr",  imem_addr, 32'h3040);
        go(1'b1);
        @(negedge clk);
        chk("postflush_stale", {31'b0, id_valid}, 32'd0);
        go(1'b1);
        @(negedge clk);
        chk("postflush_pc", id_pc, 32'h3040);

        // Misaligned fetch followed by an aligned one
        next(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        next(1'b1, 1'b0, 1'b1, 1'b1, 32'h3002);
        @(negedge clk);
        chk("mis_addr", imem_addr, 32'h3002);
        next(1'b1, 1'b0, 1'b1, 1'b1, 32'h3008);
        go(1'b1);
        @(negedge clk);
        chk("mis_pc",    id_pc, 32'h3002);
        chk("mis_flag",  {31'b0, id_misalign}, 32'd1);
        chk("mis_instr", id_instr, 32'h0);
        chk("mis_plus4", id_pc_plus4, 32'h3006);
        go(1'b1);
        @(negedge clk);
        chk("al_pc",    id_pc, 32'h3008);
        chk("al_flag",  {31'b0, id_misalign}, 32'd0);
        chk("al_instr", id_instr, 32'h3008_3008 ^ 32'h5A5A_C3C3);

        // Flush with a full buffer
        for (int i = 0; i < 3; i++) go(1'b0);
        @(negedge clk);
        chk("full_hold",  {31'b0, pc_hold},  32'd1);
        chk("full_valid", {31'b0, id_valid}, 32'd1);
        next(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        next(1'b1, 1'b0, 1'b1, 1'b1, 32'h3040);
        @(negedge clk);
        chk("fullflush_valid", {31'b0, id_valid}, 32'd0);
        chk("fullflush_addr",  imem_addr, 32'h3040);
        go(1'b1);
        go(1'b1);
        @(negedge clk);
        chk("fullflush_pc", id_pc, 32'h3040);

        // Reset in the middle of a stall
        for (int i = 0; i < 3; i++) go(1'b0);
        next(1'b0, 1'b0, 1'b0, 1'b1, 32'h3000);
        @(negedge clk);
        chk("midrst_req",   {31'b0, imem_req}, 32'd0);
        chk("midrst_valid", {31'b0, id_valid}, 32'd0);
        go(1'b1);
        @(negedge clk);
        chk("midrst_after_valid", {31'b0, id_valid}, 32'd0);
        chk("midrst_addr", imem_addr, 32'h3000);
        go(1'b1);
        go(1'b1);
        @(negedge clk);
        chk("midrst_pc", id_pc, 32'h3000);

        for (int i = 0; i < 4; i++) go(1'b1);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
